systolic_skew_feeder: RTL and testbench

// - Upstream input stage of tt_um_systolic_array.
// - Accepts one 5-lane operand vector per beat on a valid/ready interface and buffers vectors in a small FIFO.
// - Emits each vector diagonally skewed onto the array inputs: lane k is delayed k advances.
// - Drives the array enable, so the array only steps when fresh or flush data is presented.

---
 rtl/systolic_skew_feeder.sv | 140 ++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// Input stage of the systolic array: buffers 5-lane operand vectors in a small FIFO
// and emits them diagonally skewed. Optional stall counter: FEEDER_STALL_CNT_EN.
//
// state  | meaning
// IDLE   | no burst in progress; first pop starts STREAM or FLUSH
// STREAM | popping vectors on every advance; starved while the FIFO is empty
// FLUSH  | injecting zeros until the last vector clears lane 4
module systolic_skew_feeder #(
  parameter int LANES = 5,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic [WIDTH-1:0]       data_out1,
  output logic [WIDTH-1:0]       data_out2,
  output logic [WIDTH-1:0]       data_out3,
  output logic [WIDTH-1:0]       data_out4,
  output logic [WIDTH-1:0]       data_out5,
  output logic                   array_en,
  output logic                   busy,
  output logic                   done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]            stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = LANES * WIDTH + 1;
  localparam int CW = $clog2(LANES);
  localparam logic [CW-1:0] FLUSH_INIT = CW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            full, empty, push, pop, advance;
  logic [EW-1:0]   head;
  logic [CW-1:0]   flush_cnt;
  logic [WIDTH-1:0] lane_out [LANES];

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];
  assign push  = in_valid && in_ready;
  assign pop   = advance && (state != FLUSH);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, STREAM: if (advance) state_nxt = head[EW-1] ? FLUSH : STREAM;
      FLUSH:        if (advance && flush_cnt == CW'(1)) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = !full && (state != FLUSH);
    advance  = ena && ((state == FLUSH) || !empty);
    array_en = advance;
    busy     = (state != IDLE) || !empty;
  end

  // done fires in the cycle after the advance that empties the flush counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state == FLUSH) && advance && (flush_cnt == CW'(1));
      if (state != FLUSH && state_nxt == FLUSH)
        flush_cnt <= FLUSH_INIT;
      else if (state == FLUSH && advance)
        flush_cnt <= flush_cnt - CW'(1);
    end
  end

  // lane k is a k+1 deep shift chain; zeros are injected while flushing
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WIDTH-1:0] chain [k+1];
    logic [WIDTH-1:0] inj;

    assign inj = (state == FLUSH) ? '0 : head[k*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= k; j++) chain[j] <= '0;
      end else if (advance) begin
        chain[0] <= inj;
        for (int j = 1; j <= k; j++) chain[j] <= chain[j-1];
      end
    end

    assign lane_out[k] = chain[k];
  end

  assign data_out1 = lane_out[0];
  assign data_out2 = lane_out[1];
  assign data_out3 = lane_out[2];
  assign data_out4 = lane_out[3];
  assign data_out5 = lane_out[4];

`ifdef FEEDER_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (state == IDLE && state_nxt == STREAM)
      stall_cnt <= '0;
    else if (state == STREAM && ena && empty && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: stimulus queues hand-computed output
// tuples per advance, a monitor pops and compares on every array_en cycle.
module tb_systolic_skew_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [39:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [7:0]  data_out1, data_out2, data_out3, data_out4, data_out5;
  logic        array_en, busy, done;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  systolic_skew_feeder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .data_out1 (data_out1),
    .data_out2 (data_out2),
    .data_out3 (data_out3),
    .data_out4 (data_out4),
    .data_out5 (data_out5),
    .array_en  (array_en),
    .busy      (busy),
    .done      (done)
`ifdef FEEDER_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          done_cnt = 0;
  logic [39:0] exp_q[$];
  logic [39:0] last_exp = '0;
  logic [39:0] obs;
  logic        mon_adv, mon_rst_ok;
  logic [39:0] mon_e;

  assign obs = {data_out5, data_out4, data_out3, data_out2, data_out1};

  function automatic logic [39:0] vec(input logic [7:0] l0, l1, l2, l3, l4);
    return {l4, l3, l2, l1, l0};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // a lone vector appears one lane per advance, other lanes zero
  task automatic expect_single(input logic [39:0] v);
    logic [39:0] m;
    for (int k = 0; k < 5; k++) begin
      m = 40'hFF << (8 * k);
      exp_q.push_back(v & m);
    end
  endtask

  task automatic push(input logic [39:0] d, input logic l);
    int  n;
    logic acc;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #2;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout got=in_ready_low exp=accept");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic finish_burst(input int d0, input string name);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    check({name, "_done_once"}, done_cnt - d0, 1);
    check({name, "_busy_low"}, busy, 0);
    check({name, "_all_out"}, exp_q.size(), 0);
  endtask

  task automatic check_reset(input string name);
    check({name, "_data"}, obs, 0);
    check({name, "_array_en"}, array_en, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      mon_adv    = array_en;
      mon_rst_ok = rst_n;
      @(posedge clk);
      #1;
      if (!mon_rst_ok || !rst_n) begin
        last_exp = '0;
      end else if (mon_adv) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_adv got=%h exp=none", obs);
        end else begin
          mon_e = exp_q.pop_front();
          check("adv_out", obs, mon_e);
          last_exp = mon_e;
        end
      end else begin
        check("hold", obs, last_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    #3;
    check_reset("rst_init");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    ena   = 1'b1;

    // single burst
    d0 = done_cnt;
    expect_single(vec(8'h11, 8'h22, 8'h33, 8'h44, 8'h55));
    push(vec(8'h11, 8'h22, 8'h33, 8'h44, 8'h55), 1'b1);
    finish_burst(d0, "single");

    // back-pressure with ena low, then drain in order
    ena = 1'b0;
    d0  = done_cnt;
    exp_q.push_back(vec(8'hA0, 8'h00, 8'h00, 8'h00, 8'h00));
    exp_q.push_back(vec(8'hB0, 8'hA1, 8'h00, 8'h00, 8'h00));
    exp_q.push_back(vec(8'hC0, 8'hB1, 8'hA2, 8'h00, 8'h00));
    exp_q.push_back(vec(8'hD0, 8'hC1, 8'hB2, 8'hA3, 8'h00));
    exp_q.push_back(vec(8'h00, 8'hD1, 8'hC2, 8'hB3, 8'hA4));
    exp_q.push_back(vec(8'h00, 8'h00, 8'hD2, 8'hC3, 8'hB4));
    exp_q.push_back(vec(8'h00, 8'h00, 8'h00, 8'hD3, 8'hC4));
    exp_q.push_back(vec(8'h00, 8'h00, 8'h00, 8'h00, 8'hD4));
    push(vec(8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4), 1'b0);
    push(vec(8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4), 1'b0);
    push(vec(8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4), 1'b0);
    push(vec(8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4), 1'b1);
    @(negedge clk);
    check("bp_full_ready", in_ready, 0);
    @(posedge clk);
    #2;
    ena = 1'b1;
    @(negedge clk);
    check("bp_ready_before_pop", in_ready, 0);
    @(negedge clk);
    check("bp_ready_after_pop", in_ready, 1);
    @(posedge clk);
    #2;
    finish_burst(d0, "bp");

    // starvation gap between two vectors
    d0 = done_cnt;
    exp_q.push_back(vec(8'h21, 8'h00, 8'h00, 8'h00, 8'h00));
    exp_q.push_back(vec(8'h31, 8'h22, 8'h00, 8'h00, 8'h00));
    exp_q.push_back(vec(8'h00, 8'h32, 8'h23, 8'h00, 8'h00));
    exp_q.push_back(vec(8'h00, 8'h00, 8'h33, 8'h24, 8'h00));
    exp_q.push_back(vec(8'h00, 8'h00, 8'h00, 8'h34, 8'h25));
    exp_q.push_back(vec(8'h00, 8'h00, 8'h00, 8'h00, 8'h35));
    push(vec(8'h21, 8'h22, 8'h23, 8'h24, 8'h25), 1'b0);
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    push(vec(8'h31, 8'h32, 8'h33, 8'h34, 8'h35), 1'b1);
    finish_burst(d0, "starve");
`ifdef FEEDER_STALL_CNT_EN
    check("starve_stall_cnt", stall_cnt, 3);
`endif

    // ena pause in the middle of the flush
    d0 = done_cnt;
    expect_single(vec(8'h41, 8'h42, 8'h43, 8'h44, 8'h45));
    push(vec(8'h41, 8'h42, 8'h43, 8'h44, 8'h45), 1'b1);
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    ena = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    check("pause_no_early_done", done_cnt - d0, 0);
    check("pause_busy", busy, 1);
    ena = 1'b1;
    finish_burst(d0, "pause");

    // reset while flushing, then a clean burst
    expect_single(vec(8'h51, 8'h52, 8'h53, 8'h54, 8'h55));
    push(vec(8'h51, 8'h52, 8'h53, 8'h54, 8'h55), 1'b1);
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset("rst_flush");
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    rst_n = 1'b1;
`ifdef FEEDER_STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt, 0);
`endif
    d0 = done_cnt;
    expect_single(vec(8'h01, 8'h02, 8'h03, 8'h04, 8'h05));
    push(vec(8'h01, 8'h02, 8'h03, 8'h04, 8'h05), 1'b1);
    finish_burst(d0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
